// File: rtl/start_token_fifo_ctrl.sv
// Start-token FIFO: DEPTH-word shift register read at a tracked address, with occupancy tracking.
// Latency: 1 cycle write-to-read; if_dout is combinational from storage.
// Backpressure: if_full_n/if_empty_n are registered; requests against a deasserted flag are dropped.
module start_token_fifo_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic [ADDR_WIDTH:0]   if_fifo_cap
);

    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_ZERO = '0;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   cnt_q, cnt_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic                  full_n_q, empty_n_q;
    logic                  push, pop;

    assign push = if_write & if_write_ce & full_n_q;
    assign pop  = if_read  & if_read_ce  & empty_n_q;

    // Storage is deliberately unreset; only the control state is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem[i] <= mem[i-1];
            end
            mem[0] <= if_din;
        end
    end

    always_comb begin
        cnt_nxt  = cnt_q;
        addr_nxt = addr_q;
        if (push && !pop) begin
            cnt_nxt  = cnt_q + CNT_ONE;
            addr_nxt = (cnt_q != CNT_ZERO) ? addr_q + 1'b1 : '0;
        end else if (pop && !push) begin
            cnt_nxt  = cnt_q - CNT_ONE;
            addr_nxt = (cnt_q > CNT_ONE) ? addr_q - 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            addr_q    <= '0;
            empty_n_q <= 1'b0;
            full_n_q  <= 1'b1;
        end else begin
            cnt_q     <= cnt_nxt;
            addr_q    <= addr_nxt;
            empty_n_q <= (cnt_nxt != CNT_ZERO);
            full_n_q  <= (cnt_nxt != CNT_FULL);
        end
    end

    // Mux by compare so DEPTH below 2^ADDR_WIDTH never indexes past the array.
    always_comb begin
        if_dout = mem[0];
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_q == ADDR_WIDTH'(i)) begin
                if_dout = mem[i];
            end
        end
    end

    assign if_full_n         = full_n_q;
    assign if_empty_n        = empty_n_q;
    assign if_num_data_valid = cnt_q;
    assign if_fifo_cap       = CNT_FULL;

endmodule

// File: tb/tb_start_token_fifo_ctrl.sv
// Directed bench for start_token_fifo_ctrl: a DEPTH=4 and a DEPTH=2 instance, 8-bit tokens.
module tb_start_token_fifo_ctrl;

    logic clk;

    logic       rst4_n, wce4, wr4, rce4, rd4;
    logic [7:0] din4, dout4;
    logic       full4_n, empty4_n;
    logic [2:0] num4, cap4;

    logic       rst2_n, wce2, wr2, rce2, rd2;
    logic [7:0] din2, dout2;
    logic       full2_n, empty2_n;
    logic [1:0] num2, cap2;

    int n_chk = 0;
    int n_err = 0;

    start_token_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) u_d4 (
        .clk(clk), .reset_n(rst4_n),
        .if_write_ce(wce4), .if_write(wr4), .if_din(din4), .if_full_n(full4_n),
        .if_read_ce(rce4), .if_read(rd4), .if_dout(dout4), .if_empty_n(empty4_n),
        .if_num_data_valid(num4), .if_fifo_cap(cap4)
    );

    start_token_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2)) u_d2 (
        .clk(clk), .reset_n(rst2_n),
        .if_write_ce(wce2), .if_write(wr2), .if_din(din2), .if_full_n(full2_n),
        .if_read_ce(rce2), .if_read(rd2), .if_dout(dout2), .if_empty_n(empty2_n),
        .if_num_data_valid(num2), .if_fifo_cap(cap2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst4_n = 1'b0; wce4 = 1'b0; wr4 = 1'b0; rce4 = 1'b0; rd4 = 1'b0; din4 = 8'h00;
        rst2_n = 1'b0; wce2 = 1'b0; wr2 = 1'b0; rce2 = 1'b0; rd2 = 1'b0; din2 = 8'h00;
        tick();
        tick();
        rst4_n = 1'b1;
        rst2_n = 1'b1;

        chk("rst4_empty_n", 32'(empty4_n), 0);
        chk("rst4_full_n",  32'(full4_n),  1);
        chk("rst4_num",     32'(num4),     0);
        chk("cap4",         32'(cap4),     4);
        chk("cap2",         32'(cap2),     2);

        // Asynchronous reset mid-cycle on DEPTH=2 with one token held.
        wce2 = 1'b1; wr2 = 1'b1; din2 = 8'h01;
        tick();
        wr2 = 1'b0;
        chk("d2_pre_rst_num", 32'(num2), 1);
        chk("d2_pre_rst_empty_n", 32'(empty2_n), 1);
        #2 rst2_n = 1'b0;
        #1;
        chk("async_rst_empty_n", 32'(empty2_n), 0);
        chk("async_rst_full_n",  32'(full2_n),  1);
        chk("async_rst_num",     32'(num2),     0);
        tick();
        rst2_n = 1'b1;
        wr2 = 1'b1; din2 = 8'h05;
        tick();
        wr2 = 1'b0;
        chk("first_push_num",  32'(num2),  1);
        chk("first_push_dout", 32'(dout2), 8'h05);
        rd2 = 1'b1; rce2 = 1'b1;
        tick();
        rd2 = 1'b0;
        chk("d2_drain_num", 32'(num2), 0);

        // Fill DEPTH=4.
        wce4 = 1'b1; wr4 = 1'b1; din4 = 8'h11;
        tick();
        chk("fill1_empty_n", 32'(empty4_n), 1);
        chk("fill1_num",     32'(num4),     1);
        chk("fill1_dout",    32'(dout4),    8'h11);
        din4 = 8'h22; tick();
        din4 = 8'h33; tick();
        chk("fill3_full_n", 32'(full4_n), 1);
        din4 = 8'h44; tick();
        chk("fill4_full_n", 32'(full4_n), 0);
        chk("fill4_num",    32'(num4),    4);
        chk("fill4_dout",   32'(dout4),   8'h11);

        // Push while full is ignored.
        din4 = 8'h55; tick();
        wr4 = 1'b0;
        chk("full_push_num",  32'(num4),  4);
        chk("full_push_dout", 32'(dout4), 8'h11);

        // Drain in order.
        rce4 = 1'b1; rd4 = 1'b1;
        tick();
        chk("drain1_dout",   32'(dout4),   8'h22);
        chk("drain1_num",    32'(num4),    3);
        chk("drain1_full_n", 32'(full4_n), 1);
        tick();
        chk("drain2_dout", 32'(dout4), 8'h33);
        tick();
        chk("drain3_dout", 32'(dout4), 8'h44);
        chk("drain3_num",  32'(num4),  1);
        tick();
        rd4 = 1'b0;
        chk("drain4_empty_n", 32'(empty4_n), 0);
        chk("drain4_num",     32'(num4),     0);

        // Push and pop together while empty: pop blocked, token readable next cycle.
        wr4 = 1'b1; din4 = 8'hC0; rd4 = 1'b1;
        tick();
        wr4 = 1'b0; rd4 = 1'b0;
        chk("empty_both_num",     32'(num4),     1);
        chk("empty_both_empty_n", 32'(empty4_n), 1);
        chk("empty_both_dout",    32'(dout4),    8'hC0);
        rd4 = 1'b1;
        tick();
        rd4 = 1'b0;

        // Simultaneous push/pop at count=1.
        wr4 = 1'b1; din4 = 8'hA0;
        tick();
        chk("one_num",  32'(num4),  1);
        chk("one_dout", 32'(dout4), 8'hA0);
        din4 = 8'hB0; rd4 = 1'b1;
        tick();
        wr4 = 1'b0; rd4 = 1'b0;
        chk("sim1_num",  32'(num4),  1);
        chk("sim1_dout", 32'(dout4), 8'hB0);

        // Simultaneous push/pop at full, DEPTH=2.
        wr2 = 1'b1; din2 = 8'h01; tick();
        din2 = 8'h02; tick();
        chk("d2_full_n",    32'(full2_n), 0);
        chk("d2_full_dout", 32'(dout2),   8'h01);
        din2 = 8'h03; rd2 = 1'b1;
        tick();
        wr2 = 1'b0; rd2 = 1'b0;
        chk("simfull_num",    32'(num2),    1);
        chk("simfull_dout",   32'(dout2),   8'h02);
        chk("simfull_full_n", 32'(full2_n), 1);

        // Write with clock-enable low for 3 cycles.
        wce2 = 1'b0; wr2 = 1'b1; din2 = 8'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ce_gate_num", 32'(num2), 1);
        end
        wce2 = 1'b1; din2 = 8'h04;
        tick();
        wr2 = 1'b0;
        chk("ce_push_num", 32'(num2), 2);

        // Reset pulse with 2 tokens stored, then a pop is blocked.
        #2 rst2_n = 1'b0;
        #1;
        chk("rst2_num",     32'(num2),     0);
        chk("rst2_empty_n", 32'(empty2_n), 0);
        tick();
        rst2_n = 1'b1;
        rd2 = 1'b1;
        tick();
        rd2 = 1'b0;
        chk("post_rst_pop_num",     32'(num2),     0);
        chk("post_rst_pop_empty_n", 32'(empty2_n), 0);
        chk("post_rst_pop_full_n",  32'(full2_n),  1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
